// File: rtl/sr_instr_encoder_if.sv
// rtl/sr_instr_encoder_if.sv - request/output stream bundle for the instruction encoder
interface sr_instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic [31:0]       req_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;

  modport slave (
    input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm, out_ready,
    output req_ready, out_valid, out_instr, out_addr
  );

  modport master (
    output req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm, out_ready,
    input  req_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/sr_instr_encoder.sv
// rtl/sr_instr_encoder.sv - symbolic op request to RV32 word encoder with 2-entry address-tagged output FIFO
module sr_instr_encoder #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  sr_instr_encoder_if.slave   bus,
  output logic                err,
  output logic [7:0]          err_cnt
);

  localparam logic [6:0] RVOP_R       = 7'b0110011;
  localparam logic [6:0] RVOP_P       = 7'b1110111;
  localparam logic [6:0] RVOP_ADDI    = 7'b0010011;
  localparam logic [6:0] RVOP_LUI     = 7'b0110111;
  localparam logic [6:0] RVOP_BRANCH  = 7'b1100011;

  localparam logic [6:0] RVF7_ADD     = 7'b0000000;
  localparam logic [6:0] RVF7_OR      = 7'b0000000;
  localparam logic [6:0] RVF7_SRL     = 7'b0000000;
  localparam logic [6:0] RVF7_SLTU    = 7'b0000000;
  localparam logic [6:0] RVF7_SUB     = 7'b0100000;
  localparam logic [6:0] RVF7_KSLL8   = 7'b0101110;
  localparam logic [6:0] RVF7_KSLRA8  = 7'b0101111;
  localparam logic [6:0] RVF7_KSLRA8U = 7'b0110111;
  localparam logic [6:0] RVF7_KSLLI8  = 7'b0111110;

  localparam logic [2:0] RVF3_ADD     = 3'b000;
  localparam logic [2:0] RVF3_OR      = 3'b110;
  localparam logic [2:0] RVF3_SRL     = 3'b101;
  localparam logic [2:0] RVF3_SLTU    = 3'b011;
  localparam logic [2:0] RVF3_SUB     = 3'b000;
  localparam logic [2:0] RVF3_KSLL8   = 3'b000;
  localparam logic [2:0] RVF3_KSLRA8  = 3'b000;
  localparam logic [2:0] RVF3_KSLRA8U = 3'b000;
  localparam logic [2:0] RVF3_KSLLI8  = 3'b000;
  localparam logic [2:0] RVF3_ADDI    = 3'b000;
  localparam logic [2:0] RVF3_BEQ     = 3'b000;
  localparam logic [2:0] RVF3_BNE     = 3'b001;

  logic [31:0]       enc_word;
  logic              enc_legal;

  logic [31:0]       mem_instr_q [2];
  logic [31:0]       mem_instr_d [2];
  logic [ADDR_W-1:0] mem_addr_q  [2];
  logic [ADDR_W-1:0] mem_addr_d  [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              req_ready_q, req_ready_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              err_q, err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic              accept;
  logic              push;
  logic              pop;

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    unique case (bus.req_op)
      4'd0: enc_word = {RVF7_ADD,     bus.req_rs2, bus.req_rs1, RVF3_ADD,     bus.req_rd, RVOP_R};
      4'd1: enc_word = {RVF7_OR,      bus.req_rs2, bus.req_rs1, RVF3_OR,      bus.req_rd, RVOP_R};
      4'd2: enc_word = {RVF7_SRL,     bus.req_rs2, bus.req_rs1, RVF3_SRL,     bus.req_rd, RVOP_R};
      4'd3: enc_word = {RVF7_SLTU,    bus.req_rs2, bus.req_rs1, RVF3_SLTU,    bus.req_rd, RVOP_R};
      4'd4: enc_word = {RVF7_SUB,     bus.req_rs2, bus.req_rs1, RVF3_SUB,     bus.req_rd, RVOP_R};
      4'd5: enc_word = {RVF7_KSLL8,   bus.req_rs2, bus.req_rs1, RVF3_KSLL8,   bus.req_rd, RVOP_P};
      4'd6: enc_word = {RVF7_KSLRA8,  bus.req_rs2, bus.req_rs1, RVF3_KSLRA8,  bus.req_rd, RVOP_P};
      4'd7: enc_word = {RVF7_KSLRA8U, bus.req_rs2, bus.req_rs1, RVF3_KSLRA8U, bus.req_rd, RVOP_P};
      4'd8: begin
        enc_legal = ~|bus.req_imm[31:3];
        enc_word  = {RVF7_KSLLI8, 2'b01, bus.req_imm[2:0], bus.req_rs1, RVF3_KSLLI8, bus.req_rd, RVOP_P};
      end
      4'd9: begin
        // in range when the upper bits are pure sign extension of imm[11]
        enc_legal = (&bus.req_imm[31:11]) | (~|bus.req_imm[31:11]);
        enc_word  = {bus.req_imm[11:0], bus.req_rs1, RVF3_ADDI, bus.req_rd, RVOP_ADDI};
      end
      4'd10: begin
        enc_legal = ~|bus.req_imm[31:20];
        enc_word  = {bus.req_imm[19:0], bus.req_rd, RVOP_LUI};
      end
      4'd11, 4'd12: begin
        enc_legal = ((&bus.req_imm[31:12]) | (~|bus.req_imm[31:12])) & ~bus.req_imm[0];
        enc_word  = {bus.req_imm[12], bus.req_imm[10:5], bus.req_rs2, bus.req_rs1,
                     (bus.req_op == 4'd12) ? RVF3_BNE : RVF3_BEQ,
                     bus.req_imm[4:1], bus.req_imm[11], RVOP_BRANCH};
      end
      default: enc_legal = 1'b0;
    endcase
  end

  always_comb begin
    mem_instr_d = mem_instr_q;
    mem_addr_d  = mem_addr_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    waddr_d     = waddr_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;

    accept = bus.req_valid & req_ready_q;
    push   = accept & enc_legal;
    pop    = (count_q != 2'd0) & bus.out_ready;

    if (clear) begin
      rd_ptr_d  = 1'b0;
      wr_ptr_d  = 1'b0;
      count_d   = 2'd0;
      waddr_d   = BASE_ADDR;
      err_cnt_d = 8'd0;
    end else begin
      if (push) begin
        mem_instr_d[wr_ptr_q] = enc_word;
        mem_addr_d[wr_ptr_q]  = waddr_q;
        wr_ptr_d              = ~wr_ptr_q;
        waddr_d               = waddr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      // push only happens while not full, so the count never overflows
      count_d = count_q + 2'(push) - 2'(pop);
      if (accept && !enc_legal) begin
        err_d = 1'b1;
        if (err_cnt_q != 8'hFF) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
      end
    end
  end

  assign req_ready_d = (count_d != 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_instr_q <= '{32'd0, 32'd0};
      mem_addr_q  <= '{BASE_ADDR, BASE_ADDR};
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      req_ready_q <= 1'b1;
      waddr_q     <= BASE_ADDR;
      err_q       <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      mem_instr_q <= mem_instr_d;
      mem_addr_q  <= mem_addr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      req_ready_q <= req_ready_d;
      waddr_q     <= waddr_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_instr = mem_instr_q[rd_ptr_q];
  assign bus.out_addr  = mem_addr_q[rd_ptr_q];
  assign err           = err_q;
  assign err_cnt       = err_cnt_q;

endmodule
